// File: rtl/pcw_boot_pkg.sv
// Shared types for the boot download sink: FSM states, FIFO entry layout,
// default FIFO depth and the saturating byte-counter step.
package pcw_boot_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      START = 2'd3
   } boot_state_t;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } boot_entry_t;

   localparam int BOOT_FIFO_DEPTH_DEFAULT = 4;

   function automatic logic [16:0] sat_inc17(input logic [16:0] v);
      logic [16:0] r;
      if (v == 17'h1FFFF) begin
         r = v;
      end else begin
         r = v + 17'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/pcw_boot_sink_if.sv
// Download bus (dn_*) and RAM write port (mem_*) seen by the boot sink.
// master = loader/arbiter side, slave = the sink itself.
interface pcw_boot_sink_if;
   logic        dn_go;
   logic        dn_wr;
   logic [15:0] dn_addr;
   logic [7:0]  dn_data;
   logic        dn_wait;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic [7:0]  mem_data;
   logic        mem_ack;

   modport master (
      output dn_go, dn_wr, dn_addr, dn_data, mem_ack,
      input  dn_wait, mem_req, mem_addr, mem_data
   );

   modport slave (
      input  dn_go, dn_wr, dn_addr, dn_data, mem_ack,
      output dn_wait, mem_req, mem_addr, mem_data
   );
endinterface

// File: rtl/boot_sink_fifo.sv
// Small synchronous FIFO of boot_entry_t with full/empty/count and
// simultaneous push/pop (a push into a full FIFO is accepted when it also pops).
module boot_sink_fifo
   import pcw_boot_pkg::*;
#(
   parameter int DEPTH = BOOT_FIFO_DEPTH_DEFAULT
) (
   input  logic                   clk_sys,
   input  logic                   reset_n,
   input  logic                   i_push,
   input  boot_entry_t            i_entry,
   input  logic                   i_pop,
   output boot_entry_t            o_head,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   boot_entry_t   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign w_do_pop  = i_pop && (r_count != '0);
   assign w_do_push = i_push && ((r_count != FULL_COUNT) || w_do_pop);

   // Entry storage
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_entry;
      end
   end

   // Pointers and occupancy; push+pop together leaves the count unchanged
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_full  = (r_count == FULL_COUNT);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/pcw_boot_sink.sv
// Boot download sink: buffers dn_* bytes, writes them to RAM via req/ack, holds
// the CPU and issues one start pulse. Optional checksum: PCW_BOOT_CHECKSUM_EN.
module pcw_boot_sink
   import pcw_boot_pkg::*;
#(
   parameter int DEPTH = BOOT_FIFO_DEPTH_DEFAULT
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   pcw_boot_sink_if.slave bus,
   input  logic [15:0]   execute_addr,
   input  logic          execute_enable,
   output logic          cpu_hold,
   output logic          cpu_start,
   output logic [15:0]   cpu_start_addr,
   output logic [16:0]   byte_count,
   output logic          overflow,
   output logic [7:0]    checksum
);
   boot_state_t          r_state;
   boot_state_t          w_next;
   logic                 r_mem_req;
   logic [15:0]          r_mem_addr;
   logic [7:0]           r_mem_data;
   logic                 r_cpu_hold;
   logic                 r_cpu_start;
   logic [15:0]          r_cpu_start_addr;
   logic [16:0]          r_byte_count;
   logic                 r_overflow;
   logic                 r_exec_pending;
   logic [15:0]          r_exec_addr;
   boot_entry_t          w_entry;
   boot_entry_t          w_head;
   logic                 w_full;
   logic                 w_empty;
   logic [$clog2(DEPTH):0] w_count;
   logic                 w_push_try;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_set_req;
   logic                 w_clear_stats;
   logic                 w_start_entry;
   logic [15:0]          w_exec_addr;

   // Bytes are accepted only while the window is still open in LOAD
   assign w_entry       = '{addr: bus.dn_addr, data: bus.dn_data};
   assign w_push_try    = (r_state == LOAD) && bus.dn_go && bus.dn_wr;
   assign w_pop         = r_mem_req && bus.mem_ack;
   assign w_push        = w_push_try && (!w_full || w_pop);
   assign w_set_req     = (w_count != '0) && !r_mem_req;
   assign w_clear_stats = (r_state == IDLE) && (w_next == LOAD);
   assign w_start_entry = (w_next == START) && (r_state != START);
   assign w_exec_addr   = execute_enable ? execute_addr : r_exec_addr;

   boot_sink_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .i_push  (w_push),
      .i_entry (w_entry),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (bus.dn_go) begin
               w_next = LOAD;
            end else if (execute_enable && w_empty) begin
               w_next = START;
            end else begin
               w_next = IDLE;
            end
         end
         LOAD: begin
            if (!bus.dn_go) begin
               w_next = DRAIN;
            end else begin
               w_next = LOAD;
            end
         end
         DRAIN: begin
            if (bus.dn_go) begin
               w_next = LOAD;
            end else if (w_empty && !r_mem_req && r_exec_pending) begin
               w_next = START;
            end else begin
               w_next = DRAIN;
            end
         end
         START:   w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // RAM request: address/data frozen from issue until the ack cycle
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_mem_req  <= 1'b0;
         r_mem_addr <= 16'h0000;
         r_mem_data <= 8'h00;
      end else if (w_set_req) begin
         r_mem_req  <= 1'b1;
         r_mem_addr <= w_head.addr;
         r_mem_data <= w_head.data;
      end else if (w_pop) begin
         r_mem_req  <= 1'b0;
      end
   end

   // Per-download statistics
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_byte_count <= 17'd0;
         r_overflow   <= 1'b0;
      end else if (w_clear_stats) begin
         r_byte_count <= 17'd0;
         r_overflow   <= 1'b0;
      end else begin
         if (w_pop) begin
            r_byte_count <= sat_inc17(r_byte_count);
         end
         if (w_push_try && w_full && !w_pop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Execute request latch
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_exec_pending <= 1'b0;
         r_exec_addr    <= 16'h0000;
      end else if (r_state == START) begin
         r_exec_pending <= 1'b0;
      end else if (execute_enable) begin
         r_exec_pending <= 1'b1;
         r_exec_addr    <= execute_addr;
      end
   end

   // CPU control outputs, registered from the next state
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_cpu_hold       <= 1'b0;
         r_cpu_start      <= 1'b0;
         r_cpu_start_addr <= 16'h0000;
      end else begin
         r_cpu_hold  <= (w_next != IDLE);
         r_cpu_start <= w_start_entry;
         if (w_start_entry) begin
            r_cpu_start_addr <= w_exec_addr;
         end
      end
   end

`ifdef PCW_BOOT_CHECKSUM_EN
   logic [7:0] r_checksum;

   // Running modulo-256 sum of acknowledged bytes
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_checksum <= 8'h00;
      end else if (w_clear_stats) begin
         r_checksum <= 8'h00;
      end else if (w_pop) begin
         r_checksum <= r_checksum + r_mem_data;
      end
   end

   assign checksum = r_checksum;
`else
   assign checksum = 8'h00;
`endif

   assign bus.dn_wait     = w_full;
   assign bus.mem_req     = r_mem_req;
   assign bus.mem_addr    = r_mem_addr;
   assign bus.mem_data    = r_mem_data;
   assign cpu_hold        = r_cpu_hold;
   assign cpu_start       = r_cpu_start;
   assign cpu_start_addr  = r_cpu_start_addr;
   assign byte_count      = r_byte_count;
   assign overflow        = r_overflow;

endmodule

// File: tb/tb_pcw_boot_sink.sv
// Directed bench for pcw_boot_sink: a RAM-side responder with programmable ack
// latency records every write; scenario tasks drive the loader and check results.
module tb_pcw_boot_sink;
   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic [15:0] execute_addr;
   logic        execute_enable;
   logic        cpu_hold;
   logic        cpu_start;
   logic [15:0] cpu_start_addr;
   logic [16:0] byte_count;
   logic        overflow;
   logic [7:0]  checksum;

   pcw_boot_sink_if bus();

`ifdef PCW_BOOT_CHECKSUM_EN
   localparam bit CKS_EN = 1'b1;
`else
   localparam bit CKS_EN = 1'b0;
`endif

   int n_cmp = 0;
   int n_err = 0;

   int          ack_delay = 0;
   int          wait_cnt = 0;
   int          cyc = 0;
   int          req_cnt = 0;
   int          start_cnt = 0;
   int          start_cyc = -1;
   int          hold_fall_cyc = -1;
   int          last_ack_cyc = -1;
   int          proto_err = 0;
   bit          spurious_ack = 1'b0;
   bit          prev_req = 1'b0;
   bit          prev_ack = 1'b0;
   bit          prev_hold = 1'b0;
   logic [15:0] prev_addr = 16'h0000;
   logic [7:0]  prev_data = 8'h00;
   logic [15:0] wr_addr_q[$];
   logic [7:0]  wr_data_q[$];

   always #5 clk_sys = ~clk_sys;

   pcw_boot_sink #(.DEPTH(4)) dut (
      .clk_sys        (clk_sys),
      .reset_n        (reset_n),
      .bus            (bus),
      .execute_addr   (execute_addr),
      .execute_enable (execute_enable),
      .cpu_hold       (cpu_hold),
      .cpu_start      (cpu_start),
      .cpu_start_addr (cpu_start_addr),
      .byte_count     (byte_count),
      .overflow       (overflow),
      .checksum       (checksum)
   );

   // RAM-side responder and event monitor, evaluated 1 time unit after each edge
   initial begin
      bus.mem_ack = 1'b0;
      forever begin
         @(posedge clk_sys);
         #1;
         cyc++;
         if (prev_ack && bus.mem_req) proto_err++;
         if (prev_req && !prev_ack && bus.mem_req &&
             ((bus.mem_addr !== prev_addr) || (bus.mem_data !== prev_data))) proto_err++;
         if (bus.mem_req && !prev_req) req_cnt++;
         if (cpu_start === 1'b1) begin
            start_cnt++;
            start_cyc = cyc;
         end
         if (prev_hold && (cpu_hold === 1'b0)) hold_fall_cyc = cyc;
         prev_req  = bus.mem_req;
         prev_addr = bus.mem_addr;
         prev_data = bus.mem_data;
         prev_hold = cpu_hold;
         bus.mem_ack = spurious_ack;
         if (bus.mem_req === 1'b1) begin
            if (wait_cnt >= ack_delay) begin
               bus.mem_ack = 1'b1;
               wr_addr_q.push_back(bus.mem_addr);
               wr_data_q.push_back(bus.mem_data);
               last_ack_cyc = cyc;
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
         prev_ack = bus.mem_ack;
      end
   end

   function automatic logic [7:0] pat(input int i);
      return 8'(i * 7 + 3);
   endfunction

   task automatic tick();
      @(posedge clk_sys);
      #2;
   endtask

   task automatic wait_room(output bit tmo);
      int k = 0;
      while ((bus.dn_wait === 1'b1) && (k < 200)) begin
         tick();
         k++;
      end
      tmo = (bus.dn_wait === 1'b1);
   endtask

   task automatic wait_writes(input int n, input int budget, output bit tmo);
      int k = 0;
      while ((wr_addr_q.size() < n) && (k < budget)) begin
         tick();
         k++;
      end
      tmo = (wr_addr_q.size() < n);
   endtask

   task automatic wait_starts(input int n, input int budget, output bit tmo);
      int k = 0;
      while ((start_cnt < n) && (k < budget)) begin
         tick();
         k++;
      end
      tmo = (start_cnt < n);
   endtask

   task automatic clear_log();
      wr_addr_q.delete();
      wr_data_q.delete();
      start_cnt = 0;
      start_cyc = -1;
      hold_fall_cyc = -1;
      proto_err = 0;
      req_cnt = 0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      tick();
      n_cmp++; if (bus.mem_req !== 1'b0)      begin n_err++; $display("FAIL rst_mem_req: got %0h want 0", bus.mem_req); end
      n_cmp++; if (bus.mem_addr !== 16'h0000) begin n_err++; $display("FAIL rst_mem_addr: got %0h want 0", bus.mem_addr); end
      n_cmp++; if (bus.mem_data !== 8'h00)    begin n_err++; $display("FAIL rst_mem_data: got %0h want 0", bus.mem_data); end
      n_cmp++; if (bus.dn_wait !== 1'b0)      begin n_err++; $display("FAIL rst_dn_wait: got %0h want 0", bus.dn_wait); end
      n_cmp++; if (cpu_hold !== 1'b0)         begin n_err++; $display("FAIL rst_cpu_hold: got %0h want 0", cpu_hold); end
      n_cmp++; if (cpu_start !== 1'b0)        begin n_err++; $display("FAIL rst_cpu_start: got %0h want 0", cpu_start); end
      n_cmp++; if (cpu_start_addr !== 16'h0)  begin n_err++; $display("FAIL rst_start_addr: got %0h want 0", cpu_start_addr); end
      n_cmp++; if (byte_count !== 17'd0)      begin n_err++; $display("FAIL rst_byte_count: got %0h want 0", byte_count); end
      n_cmp++; if (overflow !== 1'b0)         begin n_err++; $display("FAIL rst_overflow: got %0h want 0", overflow); end
      n_cmp++; if (checksum !== 8'h00)        begin n_err++; $display("FAIL rst_checksum: got %0h want 0", checksum); end
      reset_n = 1'b1;
      tick();
      tick();
      n_cmp++; if (cpu_hold !== 1'b0) begin n_err++; $display("FAIL idle_hold: got %0h want 0", cpu_hold); end
   endtask

   task automatic test_normal_boot();
      logic [7:0] exp_sum = 8'h00;
      int n_tmo = 0;
      bit tmo;
      ack_delay = 1;
      clear_log();
      bus.dn_go = 1'b1;
      tick();
      n_cmp++; if (cpu_hold !== 1'b1) begin n_err++; $display("FAIL load_hold: got %0h want 1", cpu_hold); end
      for (int i = 0; i < 276; i++) begin
         wait_room(tmo);
         if (tmo) n_tmo++;
         bus.dn_wr = 1'b1;
         bus.dn_addr = 16'(i);
         bus.dn_data = pat(i);
         tick();
         bus.dn_wr = 1'b0;
         if (i == 0) begin
            n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL lat_n1: got %0h want 0", bus.mem_req); end
         end
         tick();
         if (i == 0) begin
            n_cmp++; if (bus.mem_req !== 1'b1) begin n_err++; $display("FAIL lat_n2: got %0h want 1", bus.mem_req); end
         end
         exp_sum = exp_sum + pat(i);
      end
      bus.dn_go = 1'b0;
      tick();
      execute_addr = 16'h0000;
      execute_enable = 1'b1;
      tick();
      execute_enable = 1'b0;
      wait_starts(1, 3000, tmo);
      if (tmo) n_tmo++;
      tick();
      tick();
      n_cmp++; if (n_tmo != 0) begin n_err++; $display("FAIL boot_timeouts: got %0d want 0", n_tmo); end
      n_cmp++; if (wr_addr_q.size() != 276) begin n_err++; $display("FAIL boot_writes: got %0d want 276", wr_addr_q.size()); end
      for (int i = 0; (i < 276) && (i < wr_addr_q.size()); i++) begin
         n_cmp++; if (wr_addr_q[i] !== 16'(i)) begin n_err++; $display("FAIL boot_addr[%0d]: got %0h want %0h", i, wr_addr_q[i], 16'(i)); end
         n_cmp++; if (wr_data_q[i] !== pat(i)) begin n_err++; $display("FAIL boot_data[%0d]: got %0h want %0h", i, wr_data_q[i], pat(i)); end
      end
      n_cmp++; if (byte_count !== 17'd276) begin n_err++; $display("FAIL boot_count: got %0d want 276", byte_count); end
      n_cmp++; if (start_cnt != 1) begin n_err++; $display("FAIL boot_starts: got %0d want 1", start_cnt); end
      n_cmp++; if (cpu_start_addr !== 16'h0000) begin n_err++; $display("FAIL boot_start_addr: got %0h want 0", cpu_start_addr); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL boot_overflow: got %0h want 0", overflow); end
      n_cmp++; if (cpu_hold !== 1'b0) begin n_err++; $display("FAIL boot_hold_end: got %0h want 0", cpu_hold); end
      n_cmp++; if (proto_err != 0) begin n_err++; $display("FAIL boot_protocol: got %0d want 0", proto_err); end
      n_cmp++; if (checksum !== (CKS_EN ? exp_sum : 8'h00)) begin n_err++; $display("FAIL boot_checksum: got %0h want %0h", checksum, (CKS_EN ? exp_sum : 8'h00)); end
   endtask

   task automatic test_backpressure();
      bit tmo;
      ack_delay = 10;
      clear_log();
      bus.dn_go = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         bus.dn_wr = 1'b1;
         bus.dn_addr = 16'h0100 + 16'(i);
         bus.dn_data = 8'h50 + 8'(i);
         tick();
         if (i == 2) begin
            n_cmp++; if (bus.dn_wait !== 1'b0) begin n_err++; $display("FAIL bp_wait_at3: got %0h want 0", bus.dn_wait); end
         end
         if (i == 3) begin
            n_cmp++; if (bus.dn_wait !== 1'b1) begin n_err++; $display("FAIL bp_wait_at4: got %0h want 1", bus.dn_wait); end
         end
      end
      bus.dn_wr = 1'b0;
      bus.dn_go = 1'b0;
      tick();
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL bp_overflow: got %0h want 1", overflow); end
      wait_writes(4, 200, tmo);
      n_cmp++; if (tmo) begin n_err++; $display("FAIL bp_drain_timeout: got %0d want 4 writes", wr_addr_q.size()); end
      for (int k = 0; k < 30; k++) tick();
      n_cmp++; if (wr_addr_q.size() != 4) begin n_err++; $display("FAIL bp_writes: got %0d want 4", wr_addr_q.size()); end
      for (int i = 0; (i < 4) && (i < wr_addr_q.size()); i++) begin
         n_cmp++; if (wr_addr_q[i] !== (16'h0100 + 16'(i))) begin n_err++; $display("FAIL bp_addr[%0d]: got %0h want %0h", i, wr_addr_q[i], 16'h0100 + 16'(i)); end
      end
      n_cmp++; if (byte_count !== 17'd4) begin n_err++; $display("FAIL bp_count: got %0d want 4", byte_count); end
      n_cmp++; if (bus.dn_wait !== 1'b0) begin n_err++; $display("FAIL bp_wait_end: got %0h want 0", bus.dn_wait); end
      execute_addr = 16'h0000;
      execute_enable = 1'b1;
      tick();
      execute_enable = 1'b0;
      wait_starts(1, 100, tmo);
      n_cmp++; if (tmo) begin n_err++; $display("FAIL bp_start_timeout: got %0d want 1 start", start_cnt); end
      tick();
      tick();
   endtask

   task automatic test_late_drain();
      bit tmo;
      ack_delay = 4;
      clear_log();
      bus.dn_go = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         bus.dn_wr = 1'b1;
         bus.dn_addr = 16'h0200 + 16'(i);
         bus.dn_data = 8'hC0 + 8'(i);
         tick();
      end
      bus.dn_wr = 1'b0;
      bus.dn_go = 1'b0;
      tick();
      execute_addr = 16'h1234;
      execute_enable = 1'b1;
      tick();
      execute_enable = 1'b0;
      n_cmp++; if (wr_addr_q.size() != 0) begin n_err++; $display("FAIL ld_queued: got %0d acked want 0", wr_addr_q.size()); end
      wait_starts(1, 200, tmo);
      n_cmp++; if (tmo) begin n_err++; $display("FAIL ld_start_timeout: got %0d want 1 start", start_cnt); end
      tick();
      tick();
      n_cmp++; if (wr_addr_q.size() != 3) begin n_err++; $display("FAIL ld_writes: got %0d want 3", wr_addr_q.size()); end
      n_cmp++; if ((start_cyc - last_ack_cyc) != 2) begin n_err++; $display("FAIL ld_start_lat: got %0d want 2", start_cyc - last_ack_cyc); end
      n_cmp++; if ((hold_fall_cyc - last_ack_cyc) != 3) begin n_err++; $display("FAIL ld_hold_lat: got %0d want 3", hold_fall_cyc - last_ack_cyc); end
      n_cmp++; if (cpu_start_addr !== 16'h1234) begin n_err++; $display("FAIL ld_start_addr: got %0h want 1234", cpu_start_addr); end
      n_cmp++; if (byte_count !== 17'd3) begin n_err++; $display("FAIL ld_count: got %0d want 3", byte_count); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ld_overflow_cleared: got %0h want 0", overflow); end
   endtask

   task automatic test_ack_ignored();
      clear_log();
      spurious_ack = 1'b1;
      tick();
      spurious_ack = 1'b0;
      tick();
      tick();
      n_cmp++; if (byte_count !== 17'd3) begin n_err++; $display("FAIL stray_ack_count: got %0d want 3", byte_count); end
      n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL stray_ack_req: got %0h want 0", bus.mem_req); end
      n_cmp++; if (wr_addr_q.size() != 0) begin n_err++; $display("FAIL stray_ack_writes: got %0d want 0", wr_addr_q.size()); end
   endtask

   task automatic test_exec_direct();
      clear_log();
      execute_addr = 16'hBEEF;
      execute_enable = 1'b1;
      tick();
      execute_enable = 1'b0;
      n_cmp++; if (cpu_start !== 1'b1) begin n_err++; $display("FAIL dx_start: got %0h want 1", cpu_start); end
      n_cmp++; if (cpu_hold !== 1'b1) begin n_err++; $display("FAIL dx_hold: got %0h want 1", cpu_hold); end
      n_cmp++; if (cpu_start_addr !== 16'hBEEF) begin n_err++; $display("FAIL dx_start_addr: got %0h want beef", cpu_start_addr); end
      tick();
      n_cmp++; if (cpu_start !== 1'b0) begin n_err++; $display("FAIL dx_start_pulse: got %0h want 0", cpu_start); end
      n_cmp++; if (cpu_hold !== 1'b0) begin n_err++; $display("FAIL dx_hold_end: got %0h want 0", cpu_hold); end
   endtask

   task automatic test_checksum();
      int n_tmo = 0;
      bit tmo;
      ack_delay = 0;
      clear_log();
      bus.dn_go = 1'b1;
      tick();
      for (int v = 1; v < 256; v++) begin
         wait_room(tmo);
         if (tmo) n_tmo++;
         bus.dn_wr = 1'b1;
         bus.dn_addr = 16'h4000 + 16'(v);
         bus.dn_data = 8'(v);
         tick();
         bus.dn_wr = 1'b0;
      end
      bus.dn_go = 1'b0;
      tick();
      execute_addr = 16'h4001;
      execute_enable = 1'b1;
      tick();
      execute_enable = 1'b0;
      wait_starts(1, 2000, tmo);
      if (tmo) n_tmo++;
      tick();
      n_cmp++; if (n_tmo != 0) begin n_err++; $display("FAIL cks_timeouts: got %0d want 0", n_tmo); end
      n_cmp++; if (byte_count !== 17'd255) begin n_err++; $display("FAIL cks_count: got %0d want 255", byte_count); end
      n_cmp++; if (checksum !== (CKS_EN ? 8'h80 : 8'h00)) begin n_err++; $display("FAIL cks_value: got %0h want %0h", checksum, (CKS_EN ? 8'h80 : 8'h00)); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL cks_overflow: got %0h want 0", overflow); end
   endtask

   task automatic test_reset_midload();
      int n_tmo = 0;
      bit tmo;
      ack_delay = 0;
      clear_log();
      bus.dn_go = 1'b1;
      tick();
      for (int i = 0; i < 100; i++) begin
         wait_room(tmo);
         if (tmo) n_tmo++;
         bus.dn_wr = 1'b1;
         bus.dn_addr = 16'h8000 + 16'(i);
         bus.dn_data = pat(i);
         tick();
         bus.dn_wr = 1'b0;
      end
      execute_addr = 16'h7777;
      execute_enable = 1'b1;
      reset_n = 1'b0;
      #1;
      execute_enable = 1'b0;
      n_cmp++; if (n_tmo != 0) begin n_err++; $display("FAIL mr_timeouts: got %0d want 0", n_tmo); end
      n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL mr_mem_req: got %0h want 0", bus.mem_req); end
      n_cmp++; if (bus.mem_addr !== 16'h0000) begin n_err++; $display("FAIL mr_mem_addr: got %0h want 0", bus.mem_addr); end
      n_cmp++; if (cpu_hold !== 1'b0) begin n_err++; $display("FAIL mr_hold: got %0h want 0", cpu_hold); end
      n_cmp++; if (byte_count !== 17'd0) begin n_err++; $display("FAIL mr_count: got %0d want 0", byte_count); end
      n_cmp++; if (bus.dn_wait !== 1'b0) begin n_err++; $display("FAIL mr_wait: got %0h want 0", bus.dn_wait); end
      n_cmp++; if (checksum !== 8'h00) begin n_err++; $display("FAIL mr_checksum: got %0h want 0", checksum); end
      bus.dn_go = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      clear_log();
      for (int k = 0; k < 20; k++) tick();
      n_cmp++; if (req_cnt != 0) begin n_err++; $display("FAIL mr_no_req: got %0d want 0", req_cnt); end
      n_cmp++; if (start_cnt != 0) begin n_err++; $display("FAIL mr_no_start: got %0d want 0", start_cnt); end
      n_cmp++; if (cpu_start_addr !== 16'h0000) begin n_err++; $display("FAIL mr_start_addr: got %0h want 0", cpu_start_addr); end
   endtask

   initial begin
      reset_n = 1'b0;
      bus.dn_go = 1'b0;
      bus.dn_wr = 1'b0;
      bus.dn_addr = 16'h0000;
      bus.dn_data = 8'h00;
      execute_addr = 16'h0000;
      execute_enable = 1'b0;
      test_reset();
      test_normal_boot();
      test_backpressure();
      test_late_drain();
      test_ack_ignored();
      test_exec_direct();
      test_checksum();
      test_reset_midload();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pcw_boot_sink.md
# pcw_boot_sink

Core-side receiver for the boot download stream, the `dn_*` bus driven by the top-level boot loader after every reset. It buffers incoming bytes in a small FIFO and writes them into main RAM through a request/acknowledge port. It holds the Z80 while a download is in progress. It issues a single start pulse carrying the execute address once every byte has been committed to RAM. It sits inside `pcw_core`, between the download bus and the memory arbiter.

## Interface
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `clk_sys` in 1: system clock, 32 MHz.
- `reset_n` in 1: asynchronous, active-low reset.
- `dn_go` in 1: download window; high while the loader is streaming.
- `dn_wr` in 1: one-cycle byte strobe.
- `dn_addr` in 16: target RAM address of the byte.
- `dn_data` in 8: byte value.
- `dn_wait` out 1: backpressure; equals FIFO full.
- `execute_addr` in 16: start address; sampled when `execute_enable` is high.
- `execute_enable` in 1: one-cycle request to start the CPU.
- `mem_req` out 1: RAM write request.
- `mem_addr` out 16: RAM write address.
- `mem_data` out 8: RAM write data.
- `mem_ack` in 1: one-cycle acknowledge from the arbiter.
- `cpu_hold` out 1: holds the Z80 in wait/reset.
- `cpu_start` out 1: one-cycle start pulse.
- `cpu_start_addr` out 16: PC load value, valid from the `cpu_start` cycle onward.
- `byte_count` out 17: number of bytes committed to RAM this download.
- `overflow` out 1: sticky; a byte was dropped.
- `checksum` out 8: see Configuration.

## Operation
- States: IDLE, LOAD, DRAIN, START.
- IDLE → LOAD when `dn_go` is high. On this transition `byte_count`, `overflow` and `checksum` are cleared.
- LOAD: each `dn_wr` pushes {`dn_addr`, `dn_data`} into the FIFO.
  - If the FIFO is full and it does not pop in the same cycle, the byte is dropped and `overflow` is set.
  - LOAD → DRAIN when `dn_go` goes low.
- DRAIN: the FIFO keeps emptying. DRAIN → START when the FIFO is empty, no request is outstanding and `exec_pending` is set.
  - If `dn_go` rises again in DRAIN, the state returns to LOAD with FIFO contents kept.
- START: drives `cpu_start` high for one cycle, then moves to IDLE.
- `execute_enable` in any state except START sets `exec_pending` and latches `execute_addr`. A later pulse overwrites the latched address. `exec_pending` clears in START.
- `execute_enable` in IDLE with an empty FIFO goes IDLE → START directly.
- `cpu_hold` is high in LOAD, DRAIN and START, and low in IDLE.
- Memory port:
  - `mem_req` rises when the FIFO head is valid and no request is outstanding.
  - `mem_addr` and `mem_data` stay stable until the `mem_ack` cycle.
  - On `mem_ack` the head pops and `byte_count` increments.
  - A `mem_ack` without a request is ignored.
- `byte_count` saturates at 0x1FFFF.
- `dn_wr` outside LOAD is ignored; this includes IDLE, DRAIN entry in the same cycle, and START.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=0, `mem_data`=0, `cpu_hold`=0, `cpu_start`=0, `cpu_start_addr`=0, `byte_count`=0, `overflow`=0, `checksum`=0, `dn_wait`=0. State is IDLE, FIFO empty, `exec_pending`=0.
- `dn_wr` at cycle N with an empty FIFO and no outstanding request gives `mem_req` high at cycle N+2: push at N, register at N+1, request visible at N+2.
- Next `mem_req` is no earlier than the cycle after `mem_ack`. `mem_req` falls in the cycle after `mem_ack`.
- A push and a pop in the same cycle are both honoured; the count is unchanged.
- Last `mem_ack` at cycle M with `exec_pending` set gives `cpu_start` at M+2, and `cpu_hold` low at M+3.
- `reset_n` low mid-download aborts the download. No further `mem_req` is issued and no `cpu_start` is produced.

## Configuration
- `PCW_BOOT_CHECKSUM_EN` defined: `checksum` is the 8-bit modulo-256 sum of `mem_data` over acknowledged writes. It is updated on the `mem_ack` cycle and cleared on IDLE → LOAD.
- Undefined: `checksum` is tied to 0 and no adder is built.

## Structure
- Package `pcw_boot_pkg` holds:
  - the `boot_state_t` enum (IDLE, LOAD, DRAIN, START);
  - the `boot_entry_t` struct {addr[15:0], data[7:0]};
  - the `BOOT_FIFO_DEPTH_DEFAULT`=4 constant.
- Sub-module `boot_sink_fifo`: a synchronous FIFO of `boot_entry_t` with full, empty and count outputs, and simultaneous push/pop. The FSM and memory port live in `pcw_boot_sink`.

## Test plan
- Normal boot:
  - Stimulus: 276-byte stream with addresses 0x0000–0x0113, `dn_wr` every 2 cycles, `mem_ack` 1 cycle after `mem_req`. Then `dn_go` falls and `execute_enable` fires with `execute_addr`=0x0000.
  - Required: 276 writes in address order with matching data; `byte_count`=276; one `cpu_start` with `cpu_start_addr`=0x0000; `overflow`=0.
- Backpressure:
  - Stimulus: `mem_ack` delayed 10 cycles, `dn_wr` every cycle for 8 bytes.
  - Required: `dn_wait` high once 4 entries are held; bytes 5–8 are dropped; `overflow`=1; `byte_count`=4.
- Late drain:
  - Stimulus: `execute_enable` with `execute_addr`=0x1234 while 3 entries are still queued.
  - Required: `cpu_start` exactly 2 cycles after the third `mem_ack`; `cpu_start_addr`=0x1234.
- Reset mid-load:
  - Stimulus: `reset_n` low after 100 bytes.
  - Required: all outputs return to their reset values; no `mem_req` or `cpu_start` until the next `dn_go`.
- Checksum (with `PCW_BOOT_CHECKSUM_EN`):
  - Stimulus: bytes 0x01..0xFF.
  - Required: `checksum`=0x80. Without the macro, `checksum` stays 0.
